// File: rtl/mips_exc_pkg.sv
// Shared exception-sequencer definitions: cause codes, status mask bits, states.
package mips_exc_pkg;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam int unsigned IE  = 0;
    localparam int unsigned SYS = 1;
    localparam int unsigned BRK = 2;
    localparam int unsigned TEQ = 3;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        REDIRECT,
        DRAIN
    } exc_state_t;

    typedef enum logic {
        KIND_EXC,
        KIND_ERET
    } exc_kind_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline/CP0-facing signal bundle of the exception sequencer.
interface exc_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        is_syscall;
    logic        is_break;
    logic        is_teq;
    logic        teq_eq;
    logic        is_eret;
    logic        stall_in;
    logic [31:0] status;
    logic [31:0] epc;

    logic        exception;
    logic        eret;
    logic [31:0] cause;
    logic [31:0] exc_pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output ex_valid, ex_pc, is_syscall, is_break, is_teq, teq_eq,
               is_eret, stall_in, status, epc,
        input  exception, eret, cause, exc_pc, flush, redirect_valid,
               redirect_pc, busy
    );

    modport slave (
        input  ex_valid, ex_pc, is_syscall, is_break, is_teq, teq_eq,
               is_eret, stall_in, status, epc,
        output exception, eret, cause, exc_pc, flush, redirect_valid,
               redirect_pc, busy
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Masked priority encoder: picks the committing event (syscall > break > teq > eret).
module exc_prio_enc
    import mips_exc_pkg::*;
(
    input  logic       ex_valid,
    input  logic       stall_in,
    input  logic       is_syscall,
    input  logic       is_break,
    input  logic       is_teq,
    input  logic       teq_eq,
    input  logic       is_eret,
    input  logic [3:0] mask,
    output logic       take,
    output logic [4:0] code,
    output exc_kind_t  kind
);

    // Qualify traps against the status mask; eret is never masked but loses to any trap.
    always_comb begin
        take = 1'b0;
        code = '0;
        kind = KIND_EXC;
        if (ex_valid && !stall_in) begin
            if (is_syscall && mask[IE] && mask[SYS]) begin
                take = 1'b1;
                code = EXC_SYSCALL;
            end else if (is_break && mask[IE] && mask[BRK]) begin
                take = 1'b1;
                code = EXC_BREAK;
            end else if (is_teq && teq_eq && mask[IE] && mask[TEQ]) begin
                take = 1'b1;
                code = EXC_TEQ;
            end else if (is_eret) begin
                take = 1'b1;
                kind = KIND_ERET;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: pulses CP0, flushes, redirects fetch, then drains.
module exc_ctrl
    import mips_exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic     clk,
    input  logic     rst,
    exc_ctrl_if.slave bus
);

    exc_state_t state, state_next;
    logic [3:0] cnt, cnt_next;
    logic [31:0] pc_q;
    logic [4:0]  code_q;
    exc_kind_t   kind_q;

    logic exception_q, eret_q, flush_q, redirect_q, busy_q;
    logic exception_d, eret_d, flush_d, redirect_d, busy_d;

    logic       take;
    logic [4:0] code;
    exc_kind_t  kind;

    logic unused_status_hi;
    assign unused_status_hi = ^bus.status[31:4];

    exc_prio_enc u_prio (
        .ex_valid   (bus.ex_valid),
        .stall_in   (bus.stall_in),
        .is_syscall (bus.is_syscall),
        .is_break   (bus.is_break),
        .is_teq     (bus.is_teq),
        .teq_eq     (bus.teq_eq),
        .is_eret    (bus.is_eret),
        .mask       (bus.status[3:0]),
        .take       (take),
        .code       (code),
        .kind       (kind)
    );

    // State, drain counter, event latches and registered output pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pc_q        <= '0;
            code_q      <= '0;
            kind_q      <= KIND_EXC;
            exception_q <= 1'b0;
            eret_q      <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            exception_q <= exception_d;
            eret_q      <= eret_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            busy_q      <= busy_d;
            if (state == IDLE && take) begin
                pc_q   <= bus.ex_pc;
                code_q <= code;
                kind_q <= kind;
            end
        end
    end

    // Next state plus the pulse values for the cycle being entered, so every
    // pulse output comes straight from a flop.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        exception_d = 1'b0;
        eret_d      = 1'b0;
        flush_d     = 1'b0;
        redirect_d  = 1'b0;
        busy_d      = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_next  = COMMIT;
                    exception_d = (kind == KIND_EXC);
                    eret_d      = (kind == KIND_ERET);
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            COMMIT: begin
                state_next = REDIRECT;
                redirect_d = 1'b1;
                flush_d    = 1'b1;
                busy_d     = 1'b1;
            end
            REDIRECT: begin
                state_next = DRAIN;
                cnt_next   = 4'(DRAIN_CYCLES - 1);
                busy_d     = 1'b1;
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                    busy_d   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ERET returns to the EPC read back during the redirect cycle itself.
    always_comb begin
        bus.redirect_pc = '0;
        if (redirect_q)
            bus.redirect_pc = (kind_q == KIND_ERET) ? bus.epc : EXC_VECTOR;
    end

    assign bus.exception      = exception_q;
    assign bus.eret           = eret_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_q;
    assign bus.busy           = busy_q;
    assign bus.cause          = {25'b0, code_q, 2'b00};
    assign bus.exc_pc         = pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios, then randomized traffic.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'h0040_0004;
    localparam int unsigned D   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exc_ctrl_if bus();

    exc_ctrl #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position within an event's timeline (0 = free).
    int          pos = 0;
    bit          m_eret = 0;
    logic [31:0] m_pc = '0;
    logic [4:0]  m_code = '0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Which event, if any, the committing instruction raises.
    task automatic qualify(output bit hit, output bit is_ret, output logic [4:0] c);
        bit          want[3];
        int unsigned bitpos[3];
        logic [4:0]  codes[3];
        want   = '{bus.is_syscall, bus.is_break, bus.is_teq & bus.teq_eq};
        bitpos = '{1, 2, 3};
        codes  = '{5'd8, 5'd9, 5'd13};
        hit = 0; is_ret = 0; c = '0;
        if (!bus.ex_valid || bus.stall_in) return;
        for (int i = 0; i < 3; i++) begin
            if (want[i] && bus.status[0] && bus.status[bitpos[i]]) begin
                hit = 1; c = codes[i];
                return;
            end
        end
        if (bus.is_eret) begin
            hit = 1; is_ret = 1;
        end
    endtask

    task automatic model_edge();
        bit hit, r; logic [4:0] c;
        if (!rst) return;
        if (pos == 0) begin
            qualify(hit, r, c);
            if (hit) begin
                pos = 1; m_eret = r; m_code = c; m_pc = bus.ex_pc;
            end
        end else begin
            pos = (pos == int'(D) + 2) ? 0 : pos + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".exception"}, 32'(bus.exception), 32'(pos == 1 && !m_eret));
        chk({tag, ".eret"}, 32'(bus.eret), 32'(pos == 1 && m_eret));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(pos == 1 || pos == 2));
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(pos == 2));
        chk({tag, ".redirect_pc"}, bus.redirect_pc,
            (pos == 2) ? (m_eret ? bus.epc : VEC) : 32'h0);
        chk({tag, ".busy"}, 32'(bus.busy), 32'(pos != 0));
        chk({tag, ".cause"}, bus.cause, {25'b0, m_code, 2'b00});
        chk({tag, ".exc_pc"}, bus.exc_pc, m_pc);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        bus.ex_valid = 0; bus.ex_pc = '0; bus.is_syscall = 0; bus.is_break = 0;
        bus.is_teq = 0; bus.teq_eq = 0; bus.is_eret = 0; bus.stall_in = 0;
    endtask

    int busy_cnt;
    int pulse_at[$];

    initial begin
        clear_inputs();
        bus.status = '0;
        bus.epc = '0;

        // Reset state
        #22;
        check_all("reset");
        rst = 1;

        // 1: unmasked syscall
        bus.status = 32'h0000_000F; bus.ex_valid = 1; bus.is_syscall = 1;
        bus.ex_pc = 32'h0040_0100;
        step("t1_commit");
        chk("t1_cause_const", bus.cause, 32'h0000_0020);
        busy_cnt = int'(bus.busy);
        clear_inputs();
        step("t1_redirect");
        chk("t1_vector_const", bus.redirect_pc, 32'h0040_0004);
        busy_cnt += int'(bus.busy);
        for (int i = 0; i < 6; i++) begin
            step("t1_drain");
            busy_cnt += int'(bus.busy);
        end
        chk("t1_busy_cycles", 32'(busy_cnt), 32'(D + 2));

        // 2: eret, unmasked even with status cleared
        bus.status = '0; bus.ex_valid = 1; bus.is_eret = 1;
        bus.ex_pc = 32'h0040_0200; bus.epc = 32'h0040_0104;
        step("t2_commit");
        clear_inputs();
        step("t2_redirect");
        chk("t2_epc_const", bus.redirect_pc, 32'h0040_0104);
        for (int i = 0; i < 5; i++) step("t2_drain");

        // 3: masked traps
        bus.status = 32'h0000_000B; bus.ex_valid = 1; bus.is_break = 1;
        for (int i = 0; i < 3; i++) step("t3_brk_masked");
        clear_inputs();
        bus.status = 32'h0000_000E; bus.ex_valid = 1; bus.is_syscall = 1;
        for (int i = 0; i < 3; i++) step("t3_ie_masked");
        clear_inputs();

        // 4: break beats teq; stall holds off acceptance
        bus.status = 32'h0000_000F; bus.ex_valid = 1; bus.is_break = 1;
        bus.is_teq = 1; bus.teq_eq = 1; bus.ex_pc = 32'h0040_0300;
        step("t4_prio");
        chk("t4_cause_const", bus.cause, 32'h0000_0024);
        clear_inputs();
        for (int i = 0; i < 6; i++) step("t4_drain");
        bus.ex_valid = 1; bus.is_break = 1; bus.is_teq = 1; bus.teq_eq = 1;
        bus.stall_in = 1; bus.ex_pc = 32'h0040_0400;
        for (int i = 0; i < 3; i++) step("t4_stalled");
        bus.stall_in = 0;
        step("t4_released");
        clear_inputs();
        for (int i = 0; i < 6; i++) step("t4_drain2");

        // 5: reset asserted during REDIRECT
        bus.ex_valid = 1; bus.is_syscall = 1; bus.ex_pc = 32'h0040_0500;
        step("t5_commit");
        clear_inputs();
        step("t5_redirect");
        #2 rst = 0;
        pos = 0; m_pc = '0; m_code = '0; m_eret = 0;
        #1 check_all("t5_async_reset");
        step("t5_in_reset");
        #2 rst = 1;
        for (int i = 0; i < 2; i++) step("t5_after_reset");
        bus.ex_valid = 1; bus.is_syscall = 1; bus.ex_pc = 32'h0040_0600;
        step("t5_new_commit");
        clear_inputs();
        for (int i = 0; i < 6; i++) step("t5_new_drain");

        // 6: syscall held throughout; re-accepted on the first IDLE cycle
        bus.ex_valid = 1; bus.is_syscall = 1; bus.ex_pc = 32'h0040_0700;
        for (int i = 0; i < 20 && pulse_at.size() < 2; i++) begin
            step("t6_held");
            if (bus.exception) pulse_at.push_back(i);
        end
        chk("t6_pulse_count", 32'(pulse_at.size()), 32'd2);
        if (pulse_at.size() == 2)
            chk("t6_pulse_gap", 32'(pulse_at[1] - pulse_at[0]), 32'(D + 3));
        clear_inputs();
        for (int i = 0; i < 6; i++) step("t6_drain");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.ex_valid   = ($urandom_range(9) < 8);
            bus.stall_in   = ($urandom_range(4) == 0);
            bus.is_syscall = ($urandom_range(3) == 0);
            bus.is_break   = ($urandom_range(3) == 0);
            bus.is_teq     = ($urandom_range(3) == 0);
            bus.teq_eq     = $urandom_range(1);
            bus.is_eret    = ($urandom_range(3) == 0);
            bus.status     = {$urandom_range(32'hFFFF), 12'h0, 4'($urandom_range(15))};
            bus.ex_pc      = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            bus.epc        = $urandom & 32'hFFFF_FFFC;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
